scatter_scheduler: RTL and testbench

Frame-level controller for the charge-scatter stage. It zeroes the charge grid, then arbitrates gyropoints from several particle-pusher streams into the single charge accumulator, one per cycle. It waits for the accumulator pipeline to drain and signals frame completion to the field solver. It sits between the pusher lanes and the accumulator and owns the grid memory write port during the clear phase.

---
 rtl/scatter_scheduler_if.sv | 40 ++++
 rtl/scatter_scheduler.sv | 142 ++++++++++++++
 tb/tb_scatter_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scatter_scheduler_if.sv
// Bundle of the frame-control, pusher-lane, accumulator and grid-clear signals
// around scatter_scheduler.
//   master : scheduler side (drives grants, accumulator feed, clear port, status)
//   slave  : environment side (drives start/count/hold and the pusher lanes)
// Signals:
//   start, num_particles, hold      frame control from the solver
//   src_valid, src_gyro, src_ready  per-stream gyropoint handshake
//   acc_valid, acc_gyro             accumulator input
//   clr_we, clr_addr                grid zero-write port
//   busy, done, issued              frame status
interface scatter_scheduler_if #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned GYRO_W  = 32
);
    logic                             start;
    logic [CNT_W-1:0]                 num_particles;
    logic                             hold;
    logic [NUM_SRC-1:0]               src_valid;
    logic [NUM_SRC-1:0][GYRO_W-1:0]   src_gyro;
    logic [NUM_SRC-1:0]               src_ready;
    logic                             acc_valid;
    logic [GYRO_W-1:0]                acc_gyro;
    logic                             clr_we;
    logic [ADDR_W-1:0]                clr_addr;
    logic                             busy;
    logic                             done;
    logic [CNT_W-1:0]                 issued;

    modport master (
        input  start, num_particles, hold, src_valid, src_gyro,
        output src_ready, acc_valid, acc_gyro, clr_we, clr_addr, busy, done, issued
    );

    modport slave (
        output start, num_particles, hold, src_valid, src_gyro,
        input  src_ready, acc_valid, acc_gyro, clr_we, clr_addr, busy, done, issued
    );
endinterface

// File: rtl/scatter_scheduler.sv
// Frame controller for the charge-scatter stage: zeroes the charge grid, then
// round-robin arbitrates gyropoints from NUM_SRC pusher streams into the single
// accumulator (one per cycle), waits for the accumulator to drain and pulses done.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  scatter_scheduler_if.master (control, pusher lanes, accumulator, clear port)
// The gyropoint (posvec_t) is carried as a flat GYRO_W-bit word.
module scatter_scheduler #(
    parameter int unsigned NUM_SRC      = 2,
    parameter int unsigned GRID_WORDS   = 4096,
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned DRAIN_CYCLES = 10,
    parameter int unsigned CNT_W        = 24,
    parameter int unsigned GYRO_W       = 32
) (
    input logic                 clk,
    input logic                 rst,
    scatter_scheduler_if.master bus
);
    localparam int unsigned PTR_W   = $clog2(NUM_SRC);
    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {StIdle, StClear, StScatter, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    issued_q, issued_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic                acc_valid_q;
    logic [GYRO_W-1:0]   acc_gyro_q, acc_gyro_d;

    logic                can_issue;
    logic                found;
    logic                handshake;
    logic [NUM_SRC-1:0]  grant;
    logic [PTR_W-1:0]    gnt_idx;
    logic [PTR_W:0]      scan;

    // Round-robin: scan from the priority pointer, wrapping modulo NUM_SRC.
    always_comb begin
        grant     = '0;
        gnt_idx   = '0;
        found     = 1'b0;
        scan      = '0;
        can_issue = (state_q == StScatter) && !bus.hold && (issued_q < count_q);
        for (int i = 0; i < NUM_SRC; i++) begin
            scan = {1'b0, ptr_q} + (PTR_W + 1)'(i);
            if (scan >= (PTR_W + 1)'(NUM_SRC)) begin
                scan = scan - (PTR_W + 1)'(NUM_SRC);
            end
            if (!found && bus.src_valid[scan[PTR_W-1:0]]) begin
                found                    = 1'b1;
                gnt_idx                  = scan[PTR_W-1:0];
                grant[scan[PTR_W-1:0]]   = 1'b1;
            end
        end
        handshake = can_issue && found;
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        issued_d   = issued_q;
        clr_addr_d = clr_addr_q;
        ptr_d      = ptr_q;
        drain_d    = drain_q;
        acc_gyro_d = acc_gyro_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    count_d    = bus.num_particles;
                    issued_d   = '0;
                    clr_addr_d = '0;
                    state_d    = StClear;
                end
            end
            StClear: begin
                if (!bus.hold) begin
                    clr_addr_d = clr_addr_q + 1'b1;
                    if (clr_addr_q == ADDR_W'(GRID_WORDS - 1)) begin
                        state_d = (count_q == '0) ? StDone : StScatter;
                    end
                end
            end
            StScatter: begin
                if (handshake) begin
                    issued_d   = issued_q + 1'b1;
                    acc_gyro_d = bus.src_gyro[gnt_idx];
                    ptr_d      = (gnt_idx == PTR_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
                    if (issued_d == count_q) begin
                        state_d = StDrain;
                        drain_d = DRAIN_W'(DRAIN_CYCLES);
                    end
                end
            end
            // Free-running: the accumulator cannot stall, so hold is ignored here.
            StDrain: begin
                if (drain_q == '0) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            issued_q    <= '0;
            clr_addr_q  <= '0;
            ptr_q       <= '0;
            drain_q     <= '0;
            acc_valid_q <= 1'b0;
            acc_gyro_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            issued_q    <= issued_d;
            clr_addr_q  <= clr_addr_d;
            ptr_q       <= ptr_d;
            drain_q     <= drain_d;
            acc_valid_q <= handshake;
            acc_gyro_q  <= acc_gyro_d;
        end
    end

    assign bus.src_ready = can_issue ? grant : '0;
    assign bus.acc_valid = acc_valid_q;
    assign bus.acc_gyro  = acc_gyro_q;
    assign bus.clr_we    = (state_q == StClear) && !bus.hold;
    assign bus.clr_addr  = clr_addr_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);
    assign bus.issued    = issued_q;
endmodule

// File: tb/tb_scatter_scheduler.sv
// Scoreboard bench for scatter_scheduler: directed frames push expected clear
// addresses, grants and accumulator words; a negedge monitor pops and compares.
module tb_scatter_scheduler;
    localparam int unsigned NUM_SRC      = 2;
    localparam int unsigned GRID_WORDS   = 16;
    localparam int unsigned ADDR_W       = 4;
    localparam int unsigned DRAIN_CYCLES = 10;
    localparam int unsigned CNT_W        = 24;
    localparam int unsigned GYRO_W       = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scatter_scheduler_if #(
        .NUM_SRC (NUM_SRC),
        .ADDR_W  (ADDR_W),
        .CNT_W   (CNT_W),
        .GYRO_W  (GYRO_W)
    ) bus ();

    scatter_scheduler #(
        .NUM_SRC      (NUM_SRC),
        .GRID_WORDS   (GRID_WORDS),
        .ADDR_W       (ADDR_W),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .CNT_W        (CNT_W),
        .GYRO_W       (GYRO_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [ADDR_W-1:0] exp_clr[$];
    int                exp_gnt[$];
    logic [GYRO_W-1:0] exp_gyro[$];
    logic [GYRO_W-1:0] sq0[$];
    logic [GYRO_W-1:0] sq1[$];

    int hs_count, hs_first, hs_last, done_seen, done_cyc, acc_run, acc_run_max, mon_g;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: compares every DUT output event against the scoreboard queues.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.clr_we) begin
                chk("clr_pending", exp_clr.size() != 0, 1);
                if (exp_clr.size() != 0) chk("clr_addr", bus.clr_addr, exp_clr.pop_front());
            end
            if ((bus.src_ready & bus.src_valid) != '0) begin
                if (hs_count == 0) hs_first = cyc;
                hs_last = cyc;
                hs_count++;
                chk("grant_pending", exp_gnt.size() != 0, 1);
                if (exp_gnt.size() != 0) begin
                    mon_g = exp_gnt.pop_front();
                    chk("grant", bus.src_ready, 64'(1) << mon_g);
                end
            end
            if (bus.acc_valid) begin
                acc_run++;
                if (acc_run > acc_run_max) acc_run_max = acc_run;
                chk("acc_pending", exp_gyro.size() != 0, 1);
                if (exp_gyro.size() != 0) chk("acc_gyro", bus.acc_gyro, exp_gyro.pop_front());
            end else begin
                acc_run = 0;
            end
            if (bus.done) begin
                done_seen++;
                done_cyc = cyc;
            end
        end
    end

    task automatic drive_srcs();
        bus.src_valid[0] = (sq0.size() != 0);
        bus.src_gyro[0]  = (sq0.size() != 0) ? sq0[0] : '0;
        bus.src_valid[1] = (sq1.size() != 0);
        bus.src_gyro[1]  = (sq1.size() != 0) ? sq1[0] : '0;
    endtask

    // One clock: note handshakes mid-cycle, then advance the stream models.
    task automatic step();
        logic [NUM_SRC-1:0] hs;
        @(negedge clk);
        hs = bus.src_valid & bus.src_ready;
        @(posedge clk);
        #1;
        if (hs[0]) void'(sq0.pop_front());
        if (hs[1]) void'(sq1.pop_front());
        drive_srcs();
    endtask

    task automatic start_frame(input int n);
        for (int a = 0; a < int'(GRID_WORDS); a++) exp_clr.push_back(ADDR_W'(a));
        hs_count         = 0;
        acc_run_max      = 0;
        bus.num_particles = CNT_W'(n);
        bus.start        = 1'b1;
        step();
        bus.start = 1'b0;
        chk("busy_after_start", bus.busy, 1);
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_seen;
        int k  = 0;
        while (done_seen == d0 && k < budget) begin
            step();
            k++;
        end
        chk("done_seen", done_seen != d0, 1);
    endtask

    task automatic flush_srcs();
        sq0.delete();
        sq1.delete();
        drive_srcs();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        hs_count = 0; hs_first = 0; hs_last = 0; done_seen = 0; done_cyc = 0;
        acc_run = 0; acc_run_max = 0; mon_g = 0;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.hold = 1'b0;
        bus.num_particles = '0;
        drive_srcs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_clr_we", bus.clr_we, 0);
        chk("rst_clr_addr", bus.clr_addr, 0);
        chk("rst_acc_valid", bus.acc_valid, 0);
        chk("rst_acc_gyro", bus.acc_gyro, 0);
        chk("rst_issued", bus.issued, 0);
        chk("rst_src_ready", bus.src_ready, 0);
        rst = 1'b1;
        step();

        // Frame with zero particles: clear only, then done.
        start_frame(0);
        chk("t1_clr_we_first", bus.clr_we, 1);
        wait_done(100);
        chk("t1_busy_after_done", bus.busy, 0);
        chk("t1_done_low", bus.done, 0);
        chk("t1_clr_all", exp_clr.size(), 0);
        chk("t1_no_acc", acc_run_max, 0);
        chk("t1_issued", bus.issued, 0);

        // Both streams valid: alternating grants.
        for (int i = 0; i < 5; i++) begin
            sq0.push_back(GYRO_W'(16'hA000 + i));
            sq1.push_back(GYRO_W'(16'hB000 + i));
        end
        drive_srcs();
        exp_gnt = '{0, 1, 0, 1, 0, 1};
        exp_gyro = '{16'hA000, 16'hB000, 16'hA001, 16'hB001, 16'hA002, 16'hB002};
        start_frame(6);
        wait_done(200);
        chk("t2_issued", bus.issued, 6);
        chk("t2_hs_count", hs_count, 6);
        chk("t2_acc_run", acc_run_max, 6);
        chk("t2_done_latency", done_cyc - hs_last, DRAIN_CYCLES + 2);
        chk("t2_busy_after_done", bus.busy, 0);
        chk("t2_ready_idle", bus.src_ready, 0);
        chk("t2_gyro_drained", exp_gyro.size(), 0);
        flush_srcs();

        // Only stream 1 valid: back-to-back grants, data in order.
        sq1 = '{16'hC000, 16'hC001, 16'hC002};
        drive_srcs();
        exp_gnt = '{1, 1, 1};
        exp_gyro = '{16'hC000, 16'hC001, 16'hC002};
        start_frame(3);
        wait_done(200);
        chk("t3_issued", bus.issued, 3);
        chk("t3_back_to_back", hs_last - hs_first, 2);
        flush_srcs();

        // hold during clear at address 7 and again mid-scatter.
        sq0 = '{16'hD000, 16'hD001};
        sq1 = '{16'hE000, 16'hE001};
        drive_srcs();
        exp_gnt = '{0, 1, 0, 1};
        exp_gyro = '{16'hD000, 16'hE000, 16'hD001, 16'hE001};
        start_frame(4);
        k = 0;
        while (bus.clr_addr != ADDR_W'(7) && k < 50) begin
            step();
            k++;
        end
        chk("t4_reached_addr7", bus.clr_addr, 7);
        bus.hold = 1'b1;
        repeat (5) begin
            #1;
            chk("t4_hold_addr", bus.clr_addr, 7);
            chk("t4_hold_we", bus.clr_we, 0);
            step();
        end
        bus.hold = 1'b0;
        k = 0;
        while (hs_count < 2 && k < 100) begin
            step();
            k++;
        end
        chk("t4_two_issued", hs_count, 2);
        bus.hold = 1'b1;
        repeat (5) begin
            #1;
            chk("t4_hold_ready", bus.src_ready, 0);
            step();
            chk("t4_hold_no_hs", hs_count, 2);
        end
        bus.hold = 1'b0;
        wait_done(200);
        chk("t4_issued", bus.issued, 4);
        chk("t4_hs_count", hs_count, 4);
        chk("t4_clr_all", exp_clr.size(), 0);
        flush_srcs();

        // Ten offered, four requested.
        for (int i = 0; i < 5; i++) begin
            sq0.push_back(GYRO_W'(16'hF000 + i));
            sq1.push_back(GYRO_W'(16'h6000 + i));
        end
        drive_srcs();
        exp_gnt = '{0, 1, 0, 1};
        exp_gyro = '{16'hF000, 16'h6000, 16'hF001, 16'h6001};
        start_frame(4);
        wait_done(200);
        repeat (3) step();
        chk("t5_issued", bus.issued, 4);
        chk("t5_hs_count", hs_count, 4);
        chk("t5_ready_after", bus.src_ready, 0);
        flush_srcs();

        // Reset during scatter, then a clean frame.
        for (int i = 0; i < 5; i++) sq0.push_back(GYRO_W'(16'h7000 + i));
        drive_srcs();
        exp_gnt = '{0, 0};
        exp_gyro = '{16'h7000, 16'h7001};
        start_frame(5);
        k = 0;
        while (hs_count < 2 && k < 100) begin
            step();
            k++;
        end
        chk("t6_two_issued", hs_count, 2);
        rst = 1'b0;
        #1;
        chk("t6_rst_src_ready", bus.src_ready, 0);
        chk("t6_rst_acc_valid", bus.acc_valid, 0);
        chk("t6_rst_acc_gyro", bus.acc_gyro, 0);
        chk("t6_rst_clr_we", bus.clr_we, 0);
        chk("t6_rst_clr_addr", bus.clr_addr, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_done", bus.done, 0);
        chk("t6_rst_issued", bus.issued, 0);
        exp_clr.delete();
        exp_gnt.delete();
        exp_gyro.delete();
        flush_srcs();
        step();
        rst = 1'b1;
        step();
        sq0 = '{16'h8000};
        sq1 = '{16'h9000};
        drive_srcs();
        exp_gnt = '{0, 1};
        exp_gyro = '{16'h8000, 16'h9000};
        start_frame(2);
        wait_done(200);
        chk("t6_issued", bus.issued, 2);
        chk("t6_hs_count", hs_count, 2);
        chk("t6_clr_all", exp_clr.size(), 0);
        chk("t6_gyro_drained", exp_gyro.size(), 0);
        chk("t6_done_latency", done_cyc - hs_last, DRAIN_CYCLES + 2);
        flush_srcs();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
